// File: rtl/dmem_ctrl.sv
// Data-side memory controller: direct-mapped write-through word cache, in-order MSHR FIFO for
// load misses and a one-entry write buffer in front of a single-port backing memory.
module dmem_ctrl #(
    parameter int unsigned IDX_BITS   = 4,
    parameter int unsigned MSHR_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mmio_req,
    input  logic        mmio_lw,
    input  logic [31:0] mmio_addr,
    input  logic [31:0] mmio_data_write,
    input  logic [4:0]  mmio_regD,
    output logic [31:0] mmio_data_read,
    output logic        hit_ack,
    output logic        miss_store,
    output logic        load_done_stall,
    output logic        passive_stall,
    output logic [4:0]  regD_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [2:0]  mshr_count
);

    localparam int unsigned LINES    = 2 ** IDX_BITS;
    localparam int unsigned TAG_BITS = 30 - IDX_BITS;
    localparam int unsigned PTR_W    = (MSHR_DEPTH > 1) ? $clog2(MSHR_DEPTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WR   = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;
    localparam logic [1:0] ST_FILL = 2'd3;

    // Request address decode; the byte offset is irrelevant for word accesses.
    logic [29:0]          req_waddr;
    logic [IDX_BITS-1:0]  req_idx;
    logic [TAG_BITS-1:0]  req_tag;
    logic                 unused_addr_bits;

    assign req_waddr        = mmio_addr[31:2];
    assign req_idx          = mmio_addr[2 +: IDX_BITS];
    assign req_tag          = mmio_addr[31 -: TAG_BITS];
    assign unused_addr_bits = ^mmio_addr[1:0];

    // Cache storage
    logic [LINES-1:0]    line_valid_q;
    logic [TAG_BITS-1:0] line_tag_q  [LINES];
    logic [31:0]         line_data_q [LINES];
    logic                req_hit;

    assign req_hit = line_valid_q[req_idx] && (line_tag_q[req_idx] == req_tag);

    // MSHR FIFO
    logic [29:0]           mshr_addr_q [MSHR_DEPTH];
    logic [4:0]            mshr_rd_q   [MSHR_DEPTH];
    logic [MSHR_DEPTH-1:0] mshr_vld_q;
    logic [PTR_W-1:0]      head_q;
    logic [PTR_W-1:0]      tail_q;
    logic [2:0]            count_q;
    logic                  mshr_full;
    logic                  mshr_empty;
    logic                  mshr_match;
    logic [29:0]           head_addr;
    logic [IDX_BITS-1:0]   fill_idx;
    logic [TAG_BITS-1:0]   fill_tag;

    assign mshr_full  = (count_q == 3'(MSHR_DEPTH));
    assign mshr_empty = (count_q == 3'd0);
    assign head_addr  = mshr_addr_q[head_q];
    assign fill_idx   = head_addr[IDX_BITS-1:0];
    assign fill_tag   = head_addr[29:IDX_BITS];
    assign mshr_count = count_q;

    // Write buffer
    logic        wb_valid_q;
    logic [29:0] wb_addr_q;
    logic [31:0] wb_data_q;

    // Port FSM and registered memory interface
    logic [1:0]  state_q;
    logic [31:0] fill_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    logic push;
    logic pop;
    logic st_accept;

    assign pop = (state_q == ST_FILL);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MSHR_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Detect a store to an address that still has a load miss outstanding.
    always_comb begin
        mshr_match = 1'b0;
        for (int i = 0; i < MSHR_DEPTH; i++) begin
            if (mshr_vld_q[i] && (mshr_addr_q[i] == req_waddr)) begin
                mshr_match = 1'b1;
            end
        end
    end

    // Prioritised one-cycle response to the memory stage.
    always_comb begin
        hit_ack         = 1'b0;
        miss_store      = 1'b0;
        load_done_stall = 1'b0;
        passive_stall   = 1'b0;
        mmio_data_read  = 32'd0;
        regD_done       = 5'd0;
        push            = 1'b0;
        st_accept       = 1'b0;
        if (state_q == ST_FILL) begin
            // Pipeline is stalled for the completion, so the request is not looked at.
            load_done_stall = 1'b1;
            mmio_data_read  = fill_q;
            regD_done       = mshr_rd_q[head_q];
        end else if (mmio_req) begin
            if (mmio_lw) begin
                if (req_hit) begin
                    hit_ack        = 1'b1;
                    mmio_data_read = line_data_q[req_idx];
                end else if (mshr_full || (wb_valid_q && (wb_addr_q == req_waddr))) begin
                    passive_stall = 1'b1;
                end else begin
                    miss_store = 1'b1;
                    push       = 1'b1;
                end
            end else begin
                if (wb_valid_q || mshr_match) begin
                    passive_stall = 1'b1;
                end else begin
                    hit_ack   = 1'b1;
                    st_accept = 1'b1;
                end
            end
        end
    end

    // Memory port sequencing; buffered writes go out before pending load misses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            fill_q      <= 32'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wb_valid_q) begin
                        state_q     <= ST_WR;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {wb_addr_q, 2'b00};
                        mem_wdata_q <= wb_data_q;
                    end else if (!mshr_empty) begin
                        state_q     <= ST_RD;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= {head_addr, 2'b00};
                        mem_wdata_q <= 32'd0;
                    end
                end
                ST_WR: begin
                    if (mem_ready) begin
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                ST_RD: begin
                    if (mem_ready) begin
                        state_q   <= ST_FILL;
                        mem_req_q <= 1'b0;
                        fill_q    <= mem_rdata;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Write buffer: loaded by an accepted store, drained by the WR completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_addr_q  <= 30'd0;
            wb_data_q  <= 32'd0;
        end else if ((state_q == ST_WR) && mem_ready) begin
            wb_valid_q <= 1'b0;
        end else if (st_accept) begin
            wb_valid_q <= 1'b1;
            wb_addr_q  <= req_waddr;
            wb_data_q  <= mmio_data_write;
        end
    end

    // MSHR pointers, occupancy and per-entry valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= 3'd0;
            mshr_vld_q <= '0;
        end else begin
            if (push) begin
                tail_q             <= ptr_inc(tail_q);
                mshr_vld_q[tail_q] <= 1'b1;
                count_q            <= count_q + 3'd1;
            end else if (pop) begin
                head_q             <= ptr_inc(head_q);
                mshr_vld_q[head_q] <= 1'b0;
                count_q            <= count_q - 3'd1;
            end
        end
    end

    // MSHR payload; qualified by the valid bits, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mshr_addr_q[tail_q] <= req_waddr;
            mshr_rd_q[tail_q]   <= mmio_regD;
        end
    end

    // Line valid bits: set only by a fill, stores never allocate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_valid_q <= '0;
        end else if (pop) begin
            line_valid_q[fill_idx] <= 1'b1;
        end
    end

    // Line tag/data: fill writes the whole line, a store hit refreshes only the data.
    always_ff @(posedge clk) begin
        if (pop) begin
            line_tag_q[fill_idx]  <= fill_tag;
            line_data_q[fill_idx] <= fill_q;
        end else if (st_accept && req_hit) begin
            line_data_q[req_idx] <= mmio_data_write;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: a transaction-level model predicts responses and memory
// transactions; independent monitors compare what the DUT presents.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mmio_req, mmio_lw;
    logic [31:0] mmio_addr, mmio_data_write, mmio_data_read;
    logic [4:0]  mmio_regD, regD_done;
    logic        hit_ack, miss_store, load_done_stall, passive_stall;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mshr_count;

    always #5 clk = ~clk;

    dmem_ctrl #(.IDX_BITS(4), .MSHR_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .mmio_req(mmio_req), .mmio_lw(mmio_lw), .mmio_addr(mmio_addr),
        .mmio_data_write(mmio_data_write), .mmio_regD(mmio_regD),
        .mmio_data_read(mmio_data_read),
        .hit_ack(hit_ack), .miss_store(miss_store),
        .load_done_stall(load_done_stall), .passive_stall(passive_stall),
        .regD_done(regD_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mshr_count(mshr_count)
    );

    localparam logic [3:0] R_HIT  = 4'b1000;
    localparam logic [3:0] R_MISS = 4'b0100;
    localparam logic [3:0] R_LDS  = 4'b0010;
    localparam logic [3:0] R_PAS  = 4'b0001;
    localparam int P_IDLE = 0, P_WR = 1, P_RD = 2, P_FILL = 3;
    localparam int DEPTH = 4;

    typedef struct packed {
        int unsigned cyc;
        logic [3:0]  resp;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [2:0]  cnt;
    } exp_t;

    typedef struct packed {
        int unsigned cyc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int unsigned len;
    } mexp_t;

    typedef struct packed {
        logic [29:0] a;
        logic [4:0]  rd;
    } mshr_t;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc_n  = 0;

    exp_t  exp_q[$];
    mexp_t mexp_q[$];

    // Reference model state
    bit          cv[16];
    logic [25:0] ct[16];
    logic [31:0] cd[16];
    mshr_t       mq[$];
    bit          wb_v;
    logic [29:0] wb_a;
    logic [31:0] wb_d;
    int          port, pcyc, plat;
    int          lat_cfg;
    bit          force_rdy;
    logic [31:0] fill_d;
    logic [31:0] bmem[logic [29:0]];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [29:0] a);
        if (bmem.exists(a)) return bmem[a];
        return 32'hC0DE_0000 ^ {2'b00, a};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 16; i++) cv[i] = 0;
        mq.delete();
        wb_v = 0;
        port = P_IDLE;
        pcyc = 0;
        plat = 0;
    endtask

    task automatic start_txn(input bit we, input logic [29:0] a, input logic [31:0] d);
        mexp_t m;
        port = we ? P_WR : P_RD;
        pcyc = 1;
        plat = (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 4));
        m.cyc = cyc_n + 1;
        m.we = we;
        m.addr = {a, 2'b00};
        m.wdata = d;
        m.len = plat;
        mexp_q.push_back(m);
    endtask

    // Drive one cycle of stimulus, record the predicted response, advance the model past the edge.
    task automatic drive(input bit req, input bit lw, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, output logic [3:0] r);
        logic [29:0] wa;
        int idx;
        bit hit, pend, rdy, acc_st;
        exp_t e;
        mshr_t h;
        wa  = addr[31:2];
        idx = int'(wa[3:0]);
        hit = cv[idx] && (ct[idx] == wa[29:4]);
        rdy = ((port == P_WR) || (port == P_RD)) && (pcyc == plat);
        mem_ready = rdy | force_rdy;
        if (rdy && port == P_RD) mem_rdata = mem_val(mq[0].a);
        else mem_rdata = $urandom();
        mmio_req = req;
        mmio_lw = lw;
        mmio_addr = addr;
        mmio_data_write = wd;
        mmio_regD = rd;
        e.cyc = cyc_n;
        e.resp = 4'b0;
        e.data = 32'd0;
        e.rd = 5'd0;
        e.cnt = 3'(mq.size());
        acc_st = 0;
        if (port == P_FILL) begin
            e.resp = R_LDS;
            e.data = fill_d;
            e.rd = mq[0].rd;
        end else if (req) begin
            if (lw) begin
                if (hit) begin
                    e.resp = R_HIT;
                    e.data = cd[idx];
                end else if (mq.size() == DEPTH || (wb_v && wb_a == wa)) e.resp = R_PAS;
                else e.resp = R_MISS;
            end else begin
                pend = 0;
                foreach (mq[i]) if (mq[i].a == wa) pend = 1;
                if (wb_v || pend) e.resp = R_PAS;
                else begin
                    e.resp = R_HIT;
                    acc_st = 1;
                end
            end
        end
        if (e.resp != 4'b0) exp_q.push_back(e);
        r = e.resp;
        case (port)
            P_IDLE: begin
                if (wb_v) start_txn(1, wb_a, wb_d);
                else if (mq.size() > 0) start_txn(0, mq[0].a, 32'd0);
            end
            P_WR: begin
                if (rdy) begin
                    bmem[wb_a] = wb_d;
                    wb_v = 0;
                    port = P_IDLE;
                end else pcyc++;
            end
            P_RD: begin
                if (rdy) begin
                    fill_d = mem_val(mq[0].a);
                    port = P_FILL;
                end else pcyc++;
            end
            default: begin
                h = mq.pop_front();
                cv[h.a[3:0]] = 1;
                ct[h.a[3:0]] = h.a[29:4];
                cd[h.a[3:0]] = fill_d;
                port = P_IDLE;
            end
        endcase
        if (e.resp == R_MISS) mq.push_back({wa, rd});
        if (acc_st) begin
            wb_v = 1;
            wb_a = wa;
            wb_d = wd;
            if (hit) cd[idx] = wd;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic run(input bit req, input bit lw, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd);
        logic [3:0] r;
        drive(req, lw, addr, wd, rd, r);
        tick();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) run(0, 0, 32'd0, 32'd0, 5'd0);
    endtask

    task automatic drain();
        for (int k = 0; k < 400; k++) begin
            if (port == P_IDLE && mq.size() == 0 && !wb_v) break;
            run(0, 0, 32'd0, 32'd0, 5'd0);
        end
    endtask

    // Retry a request until the model accepts it with the wanted response.
    task automatic issue_until(input bit lw, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [4:0] rd, input logic [3:0] want);
        logic [3:0] r;
        for (int k = 0; k < 200; k++) begin
            drive(1, lw, addr, wd, rd, r);
            tick();
            if (r == want) break;
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_resp"}, {hit_ack, miss_store, load_done_stall, passive_stall}, 4'b0);
        chk({tag, "_rdata"}, mmio_data_read, 32'd0);
        chk({tag, "_regD_done"}, regD_done, 5'd0);
        chk({tag, "_mem_ctl"}, {mem_req, mem_we}, 2'b0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_mshr_count"}, mshr_count, 3'd0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        mmio_req = 0;
        mmio_lw = 0;
        mmio_addr = 0;
        mmio_data_write = 0;
        mmio_regD = 0;
        mem_ready = 0;
        mem_rdata = 0;
        #1;
        reset_checks("midrst");
        model_clear();
        exp_q.delete();
        mexp_q.delete();
        tick();
        rst = 1'b0;
    endtask

    // Response monitor
    exp_t        e_mon;
    logic [3:0]  resp_now;
    always @(negedge clk) begin
        if (!rst) begin
            resp_now = {hit_ack, miss_store, load_done_stall, passive_stall};
            if (resp_now != 4'b0) begin
                if (exp_q.size() == 0) chk("unexpected_resp", resp_now, 4'b0);
                else begin
                    e_mon = exp_q.pop_front();
                    chk("resp_cycle", cyc_n, e_mon.cyc);
                    chk("resp", resp_now, e_mon.resp);
                    chk("rdata", mmio_data_read, e_mon.data);
                    chk("regD_done", regD_done, e_mon.rd);
                    chk("mshr_count", mshr_count, e_mon.cnt);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc_n) begin
                e_mon = exp_q.pop_front();
                chk("missing_resp", resp_now, e_mon.resp);
            end else begin
                chk("idle_outputs", {mmio_data_read, 3'b0, regD_done}, 40'd0);
            end
        end
    end

    // Memory-interface monitor
    mexp_t       me_mon;
    bit          m_inflight = 0;
    int unsigned m_cnt, m_len;
    always @(negedge clk) begin
        if (rst) begin
            m_inflight = 0;
        end else if (mem_req && !m_inflight) begin
            if (mexp_q.size() == 0) chk("unexpected_mem_req", mem_req, 1'b0);
            else begin
                me_mon = mexp_q.pop_front();
                chk("mem_req_cycle", cyc_n, me_mon.cyc);
                chk("mem_we", mem_we, me_mon.we);
                chk("mem_addr", mem_addr, me_mon.addr);
                chk("mem_wdata", mem_wdata, me_mon.wdata);
                m_len = me_mon.len;
                m_cnt = 1;
                m_inflight = 1;
            end
        end else if (mem_req && m_inflight) begin
            m_cnt++;
        end else if (!mem_req && m_inflight) begin
            chk("mem_req_len", m_cnt, m_len);
            m_inflight = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        logic [29:0] wa;
        rst = 1'b1;
        force_rdy = 0;
        lat_cfg = 0;
        mmio_req = 0;
        mmio_lw = 0;
        mmio_addr = 0;
        mmio_data_write = 0;
        mmio_regD = 0;
        mem_ready = 0;
        mem_rdata = 0;
        model_clear();
        #2;
        reset_checks("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic miss, fill, then hit
        lat_cfg = 3;
        bmem[30'h10] = 32'h1234;
        drive(1, 1, 32'h40, 32'd0, 5'd5, r);
        #1;
        chk("s1_miss_store", miss_store, 1'b1);
        tick();
        drain();
        chk("s1_count_zero", mshr_count, 3'd0);
        drive(1, 1, 32'h40, 32'd0, 5'd6, r);
        #1;
        chk("s1_hit_ack", hit_ack, 1'b1);
        chk("s1_hit_data", mmio_data_read, 32'h1234);
        tick();

        // Four outstanding misses, fifth stalls until the first pop
        lat_cfg = 10;
        for (int i = 1; i <= 4; i++) run(1, 1, 32'(i) << 8, 32'd0, 5'(i));
        chk("s2_count_full", mshr_count, 3'd4);
        issue_until(1, 32'h500, 32'd0, 5'd5, R_MISS);
        drain();

        // Hit under miss
        lat_cfg = 5;
        issue_until(1, 32'h40, 32'd0, 5'd7, R_MISS);
        drain();
        run(1, 1, 32'h80, 32'd0, 5'd8);
        drive(1, 1, 32'h40, 32'd0, 5'd9, r);
        #1;
        chk("s3_hit_under_miss", hit_ack, 1'b1);
        tick();
        drain();

        // Store to cached line, back-to-back store stalls
        issue_until(1, 32'h40, 32'd0, 5'd10, R_MISS);
        drain();
        drive(1, 0, 32'h40, 32'hAA, 5'd0, r);
        #1;
        chk("s4_store_ack", hit_ack, 1'b1);
        tick();
        drive(1, 0, 32'h44, 32'hBB, 5'd0, r);
        #1;
        chk("s4_store_stall", passive_stall, 1'b1);
        tick();
        drain();
        drive(1, 1, 32'h40, 32'd0, 5'd11, r);
        #1;
        chk("s4_load_after_store", mmio_data_read, 32'hAA);
        tick();

        // Load to an address with a buffered uncached store
        run(1, 0, 32'h600, 32'h5A5A, 5'd0);
        drive(1, 1, 32'h600, 32'd0, 5'd12, r);
        #1;
        chk("s5_raw_stall", passive_stall, 1'b1);
        tick();
        issue_until(1, 32'h600, 32'd0, 5'd12, R_MISS);
        drain();
        drive(1, 1, 32'h600, 32'd0, 5'd13, r);
        #1;
        chk("s5_fill_data", mmio_data_read, 32'h5A5A);
        tick();

        // Randomised traffic
        lat_cfg = 0;
        for (int k = 0; k < 1500; k++) begin
            wa = 30'($urandom_range(0, 31));
            run(($urandom % 10) < 6, $urandom % 2, {wa, 2'($urandom)}, $urandom, 5'($urandom));
        end
        drain();

        // Reset while a read is outstanding; the late ready must be ignored
        lat_cfg = 6;
        issue_until(1, 32'h700, 32'd0, 5'd9, R_MISS);
        for (int k = 0; k < 20; k++) begin
            if (port == P_RD && pcyc >= 2) break;
            idle(1);
        end
        apply_reset();
        idle(1);
        force_rdy = 1;
        idle(1);
        force_rdy = 0;
        idle(12);
        chk("s6_count_after_reset", mshr_count, 3'd0);
        chk("s6_mem_req_after_reset", mem_req, 1'b0);

        idle(3);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("mexp_q_empty", mexp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
